// File: rtl/harness_pkg.sv
// ---------------------------------------------------------------------------
// harness_pkg
// Shared types for the scan-check harness.
//   state_t       : harness sequencing states
//   trace_entry_t : layout of one trace FIFO entry at the default widths
//                   (cycle index, destination register, written data)
//   TRACE_W       : bit width of trace_entry_t
//   trace_width() : entry width for arbitrary parameter choices
// ---------------------------------------------------------------------------
package harness_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_CYCLE_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  // "reg" is a keyword, so the register field is called reg_idx.
  typedef struct packed {
    logic [DEF_CYCLE_W-1:0]    cycle;
    logic [DEF_REG_ADDR_W-1:0] reg_idx;
    logic [DEF_DATA_W-1:0]     data;
  } trace_entry_t;

  localparam int TRACE_W = $bits(trace_entry_t);

  // Entry width for non-default parameterisations; field order is always
  // {cycle, reg, data} from MSB to LSB.
  function automatic int trace_width(input int cycle_w, input int addr_w,
                                     input int data_w);
    return cycle_w + addr_w + data_w;
  endfunction

endpackage

// File: rtl/harness_trace_fifo.sv
// ---------------------------------------------------------------------------
// harness_trace_fifo
// Synchronous FIFO with a registered head word and drop-on-full behaviour.
//   clock    : rising-edge clock
//   reset    : synchronous active-high reset (empties FIFO, clears flags)
//   clear    : synchronous flush (same effect as reset)
//   push/din : write request and data
//   pop      : read request; ignored while empty
//   head     : registered copy of the oldest entry, valid while !empty
//   empty    : no entries held
//   overflow : sticky, set when a push was dropped because the FIFO was full
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module harness_trace_fifo #(
  parameter int WIDTH = 53,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_inc;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] head_reg;
  logic             overflow_reg;

  logic full;
  logic do_pop;
  logic do_push;
  logic drop;

  assign full       = (count_reg == DEPTH_C);
  assign empty      = (count_reg == '0);
  assign do_pop     = pop && !empty && !clear;
  // Room appears in a full FIFO when the head leaves in the same cycle.
  assign do_push    = push && !clear && (!full || do_pop);
  assign drop       = push && !clear && full && !do_pop;
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      // Head register: with more than one entry the successor is already in
      // memory; with exactly one, the successor can only be the word being
      // pushed this cycle. An empty FIFO takes the pushed word directly.
      if (do_pop) begin
        if (count_reg > ONE_C) begin
          head_reg <= mem[rd_ptr_inc];
        end else if (do_push) begin
          head_reg <= din;
        end
      end else if (do_push && empty) begin
        head_reg <= din;
      end
    end
  end

  assign head     = head_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/harness_scan_checker.sv
// ---------------------------------------------------------------------------
// harness_scan_checker
// On-chip self-check harness: traces processor writebacks for num_cycles
// clocks, then scans the register file through read port A and compares
// each register against an expected-value ROM.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start, num_cycles     : begin a run (IDLE/DONE only), run length
//   wb_en/wb_reg/wb_data  : processor writeback observation
//   test_mode, scan_addr  : regfile port A takeover and address
//   scan_data             : regfile port A data (combinational read)
//   exp_addr, exp_data    : expected ROM address / data (1-cycle latency)
//   busy, done, pass      : status
//   error_count, fail_*   : mismatch count and first failing register
//   trace_rd, trace_*     : trace FIFO pop and registered head entry
//   trace_overflow        : sticky, a trace entry was dropped
// ---------------------------------------------------------------------------
module harness_scan_checker
  import harness_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int NUM_REGS    = 32,
  parameter int CYCLE_W     = 16,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CYCLE_W-1:0]    num_cycles,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  test_mode,
  output logic [REG_ADDR_W-1:0] scan_addr,
  input  logic [DATA_W-1:0]     scan_data,
  output logic [REG_ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0]     exp_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [REG_ADDR_W:0]   error_count,
  output logic                  fail_valid,
  output logic [REG_ADDR_W-1:0] fail_reg,
  output logic [DATA_W-1:0]     fail_exp,
  output logic [DATA_W-1:0]     fail_act,
  input  logic                  trace_rd,
  output logic                  trace_valid,
  output logic [CYCLE_W-1:0]    trace_cycle,
  output logic [REG_ADDR_W-1:0] trace_reg,
  output logic [DATA_W-1:0]     trace_data,
  output logic                  trace_overflow
);

  localparam int ENTRY_W = trace_width(CYCLE_W, REG_ADDR_W, DATA_W);
  // One extra bit so the index can reach NUM_REGS (the drain cycle).
  localparam int IDX_W = REG_ADDR_W + 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_REGS);
  localparam logic [REG_ADDR_W:0] ERR_MAX  = (REG_ADDR_W+1)'(NUM_REGS);

  state_t state_reg;
  state_t state_next;

  logic [CYCLE_W-1:0]    cnt_reg;
  logic [CYCLE_W-1:0]    ncyc_reg;
  logic [IDX_W-1:0]      idx_reg;

  // Compare pipeline stage: regfile data captured one cycle before the
  // ROM word for the same address becomes available.
  logic                  s1_valid_reg;
  logic [REG_ADDR_W-1:0] s1_addr_reg;
  logic [DATA_W-1:0]     s1_act_reg;

  logic [REG_ADDR_W:0]   err_reg;
  logic                  fail_valid_reg;
  logic [REG_ADDR_W-1:0] fail_reg_reg;
  logic [DATA_W-1:0]     fail_exp_reg;
  logic [DATA_W-1:0]     fail_act_reg;

  logic start_ok;
  logic run_last;
  logic scan_active;
  logic mismatch;

  logic                fifo_push;
  logic [ENTRY_W-1:0]  fifo_din;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                fifo_empty;
  logic                fifo_overflow;

  assign start_ok    = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign run_last    = ((cnt_reg + 1'b1) == ncyc_reg);
  assign scan_active = (state_reg == SCAN) && (idx_reg < LAST_IDX);
  assign mismatch    = s1_valid_reg && (s1_act_reg != exp_data);

  // -------------------------------------------------------------------------
  // State register and next-state logic
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = (num_cycles == '0) ? SCAN : RUN;
        end
      end
      RUN: begin
        if (run_last) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        // Index NUM_REGS is the drain cycle in which the final compare runs.
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Counters, compare pipeline and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg        <= '0;
      ncyc_reg       <= '0;
      idx_reg        <= '0;
      s1_valid_reg   <= 1'b0;
      s1_addr_reg    <= '0;
      s1_act_reg     <= '0;
      err_reg        <= '0;
      fail_valid_reg <= 1'b0;
      fail_reg_reg   <= '0;
      fail_exp_reg   <= '0;
      fail_act_reg   <= '0;
    end else if (start_ok) begin
      cnt_reg        <= '0;
      ncyc_reg       <= num_cycles;
      idx_reg        <= '0;
      s1_valid_reg   <= 1'b0;
      err_reg        <= '0;
      fail_valid_reg <= 1'b0;
      fail_reg_reg   <= '0;
      fail_exp_reg   <= '0;
      fail_act_reg   <= '0;
    end else begin
      // Counter holds at num_cycles so it cannot wrap within a run.
      if ((state_reg == RUN) && (cnt_reg != ncyc_reg)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if ((state_reg == SCAN) && (idx_reg != LAST_IDX)) begin
        idx_reg <= idx_reg + 1'b1;
      end
      s1_valid_reg <= scan_active;
      s1_addr_reg  <= idx_reg[REG_ADDR_W-1:0];
      s1_act_reg   <= scan_data;
      if (mismatch) begin
        if (err_reg != ERR_MAX) begin
          err_reg <= err_reg + 1'b1;
        end
        if (!fail_valid_reg) begin
          fail_valid_reg <= 1'b1;
          fail_reg_reg   <= s1_addr_reg;
          fail_exp_reg   <= exp_data;
          fail_act_reg   <= s1_act_reg;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Trace FIFO
  // -------------------------------------------------------------------------
  assign fifo_push = (state_reg == RUN) && wb_en && (wb_reg != '0);
  assign fifo_din  = {cnt_reg, wb_reg, wb_data};

  harness_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (start_ok),
    .push     (fifo_push),
    .din      (fifo_din),
    .pop      (trace_rd),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .overflow (fifo_overflow)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign test_mode      = (state_reg == SCAN);
  assign scan_addr      = scan_active ? idx_reg[REG_ADDR_W-1:0] : '0;
  assign exp_addr       = scan_addr;
  assign busy           = (state_reg == RUN) || (state_reg == SCAN);
  assign done           = (state_reg == DONE);
  assign pass           = done && (err_reg == '0);
  assign error_count    = err_reg;
  assign fail_valid     = fail_valid_reg;
  assign fail_reg       = fail_reg_reg;
  assign fail_exp       = fail_exp_reg;
  assign fail_act       = fail_act_reg;
  assign trace_valid    = !fifo_empty;
  assign trace_cycle    = fifo_head[ENTRY_W-1 -: CYCLE_W];
  assign trace_reg      = fifo_head[DATA_W +: REG_ADDR_W];
  assign trace_data     = fifo_head[DATA_W-1:0];
  assign trace_overflow = fifo_overflow;

endmodule

// File: tb/tb_harness_scan_checker.sv
// ---------------------------------------------------------------------------
// tb_harness_scan_checker
// Table of run scenarios (writeback pattern, regfile/ROM differences and the
// expected results) applied in a loop; a queue scoreboard predicts trace FIFO
// contents. Hand-written sequences cover reset in the middle of a scan.
// ---------------------------------------------------------------------------
module tb_harness_scan_checker;
  import harness_pkg::*;

  localparam int NUM_REGS = 32;
  localparam int DEPTH    = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] num_cycles;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        test_mode;
  logic [4:0]  scan_addr;
  logic [31:0] scan_data;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic [5:0]  error_count;
  logic        fail_valid;
  logic [4:0]  fail_reg;
  logic [31:0] fail_exp;
  logic [31:0] fail_act;
  logic        trace_rd;
  logic        trace_valid;
  logic [15:0] trace_cycle;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;
  logic        trace_overflow;

  always #5 clock = ~clock;

  harness_scan_checker dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .num_cycles     (num_cycles),
    .wb_en          (wb_en),
    .wb_reg         (wb_reg),
    .wb_data        (wb_data),
    .test_mode      (test_mode),
    .scan_addr      (scan_addr),
    .scan_data      (scan_data),
    .exp_addr       (exp_addr),
    .exp_data       (exp_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .error_count    (error_count),
    .fail_valid     (fail_valid),
    .fail_reg       (fail_reg),
    .fail_exp       (fail_exp),
    .fail_act       (fail_act),
    .trace_rd       (trace_rd),
    .trace_valid    (trace_valid),
    .trace_cycle    (trace_cycle),
    .trace_reg      (trace_reg),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow)
  );

  // Register file (combinational read) and expected ROM (registered read).
  logic [31:0] rf  [NUM_REGS];
  logic [31:0] rom [NUM_REGS];
  assign scan_data = rf[scan_addr];
  always @(posedge clock) exp_data <= rom[exp_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  typedef struct {
    int          ncyc;
    int          burst;     // nonzero: write b_reg every cycle, data 0x100+k
    int          b_reg;
    int          pop_cyc;   // cycle in which trace_rd is pulsed, -1 none
    int          w0_cyc;
    int          w0_reg;
    logic [31:0] w0_data;
    int          w1_cyc;
    int          w1_reg;
    logic [31:0] w1_data;
    int          t0_reg;  logic [31:0] t0_rf;  logic [31:0] t0_rom;
    int          t1_reg;  logic [31:0] t1_rf;  logic [31:0] t1_rom;
    int          t2_reg;  logic [31:0] t2_rf;  logic [31:0] t2_rom;
    int          e_err;
    logic        e_fv;
    int          e_freg;
    logic [31:0] e_fexp;
    logic [31:0] e_fact;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic set_pair(input int r, input logic [31:0] a, input logic [31:0] e);
    if ((a | e) != 32'd0) begin
      rf[r]  = a;
      rom[r] = e;
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    trace_entry_t q[$];
    trace_entry_t e;
    int done_k;
    int guard;
    for (int i = 0; i < NUM_REGS; i++) begin
      rf[i]  = 32'd0;
      rom[i] = 32'd0;
    end
    set_pair(v.t0_reg, v.t0_rf, v.t0_rom);
    set_pair(v.t1_reg, v.t1_rf, v.t1_rom);
    set_pair(v.t2_reg, v.t2_rf, v.t2_rom);

    @(negedge clock);
    start      = 1'b1;
    num_cycles = 16'(v.ncyc);
    @(posedge clock);
    done_k = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      start    = 1'b0;
      wb_en    = 1'b0;
      wb_reg   = 5'd0;
      wb_data  = 32'd0;
      trace_rd = 1'b0;
      if (done) begin
        done_k = k;
        break;
      end
      if (k == 0) chk($sformatf("v%0d_busy_after_start", id), busy, 1);
      if (k == v.ncyc) chk($sformatf("v%0d_scan_entry_test_mode", id), test_mode, 1);
      if (v.ncyc > 0 && k == v.ncyc - 1)
        chk($sformatf("v%0d_last_run_test_mode", id), test_mode, 0);
      // A start during RUN/SCAN must be ignored.
      if (k == 2) begin
        start      = 1'b1;
        num_cycles = 16'd1;
      end
      if (v.burst != 0) begin
        wb_en = 1'b1; wb_reg = 5'(v.b_reg); wb_data = 32'h100 + 32'(k);
      end else if (k == v.w0_cyc) begin
        wb_en = 1'b1; wb_reg = 5'(v.w0_reg); wb_data = v.w0_data;
      end else if (k == v.w1_cyc) begin
        wb_en = 1'b1; wb_reg = 5'(v.w1_reg); wb_data = v.w1_data;
      end
      if (k == v.pop_cyc) begin
        trace_rd = 1'b1;
        if (q.size() > 0) begin
          chk($sformatf("v%0d_head_before_pop", id),
              {trace_cycle, trace_reg, trace_data}, q[0]);
          void'(q.pop_front());
        end
      end
      if (k < v.ncyc && wb_en && wb_reg != 5'd0 && q.size() < DEPTH) begin
        e.cycle   = 16'(k);
        e.reg_idx = wb_reg;
        e.data    = wb_data;
        q.push_back(e);
      end
    end

    $display("run %0d: ncyc=%0d done_k=%0d err=%0d fail_reg=%0d pass=%0b ovf=%0b",
             id, v.ncyc, done_k, error_count, fail_reg, pass, trace_overflow);
    chk($sformatf("v%0d_done_latency", id), 64'(done_k), 64'(v.ncyc + NUM_REGS + 1));
    chk($sformatf("v%0d_test_mode_done", id), test_mode, 0);
    chk($sformatf("v%0d_busy_done", id), busy, 0);
    chk($sformatf("v%0d_error_count", id), error_count, 64'(v.e_err));
    chk($sformatf("v%0d_fail_valid", id), fail_valid, v.e_fv);
    if (v.e_fv) begin
      chk($sformatf("v%0d_fail_reg", id), fail_reg, 64'(v.e_freg));
      chk($sformatf("v%0d_fail_exp", id), fail_exp, v.e_fexp);
      chk($sformatf("v%0d_fail_act", id), fail_act, v.e_fact);
    end
    chk($sformatf("v%0d_pass", id), pass, (v.e_err == 0));
    chk($sformatf("v%0d_overflow", id), trace_overflow, v.e_ovf);

    guard = 0;
    while (q.size() > 0 && guard < 64) begin
      chk($sformatf("v%0d_trace_valid", id), trace_valid, 1);
      chk($sformatf("v%0d_trace_head", id), {trace_cycle, trace_reg, trace_data}, q[0]);
      void'(q.pop_front());
      trace_rd = 1'b1;
      @(negedge clock);
      trace_rd = 1'b0;
      guard++;
    end
    chk($sformatf("v%0d_trace_empty", id), trace_valid, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_cycles = 16'd0;
    wb_en = 1'b0; wb_reg = 5'd0; wb_data = 32'd0; trace_rd = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rf[i] = 32'd0; rom[i] = 32'd0;
    end

    for (int i = 0; i < 6; i++) begin
      vecs[i] = '{default: 0};
      vecs[i].pop_cyc = -1;
    end
    // Two mismatches; r9 matches; first failure is r4.
    vecs[0].ncyc = 3;
    vecs[0].t0_reg = 4;  vecs[0].t0_rf = 32'd5; vecs[0].t0_rom = 32'd6;
    vecs[0].t1_reg = 9;  vecs[0].t1_rf = 32'd2; vecs[0].t1_rom = 32'd2;
    vecs[0].t2_reg = 31; vecs[0].t2_rf = 32'd1; vecs[0].t2_rom = 32'd0;
    vecs[0].e_err = 2; vecs[0].e_fv = 1'b1; vecs[0].e_freg = 4;
    vecs[0].e_fexp = 32'd6; vecs[0].e_fact = 32'd5;
    // Passing run from DONE; r0 write is not traced.
    vecs[1].ncyc = 5;
    vecs[1].w0_cyc = 1; vecs[1].w0_reg = 3; vecs[1].w0_data = 32'd7;
    vecs[1].w1_cyc = 2; vecs[1].w1_reg = 0; vecs[1].w1_data = 32'd9;
    vecs[1].t0_reg = 3; vecs[1].t0_rf = 32'd7; vecs[1].t0_rom = 32'd7;
    // Zero-length run: no pushes, r0 mismatch is first register.
    vecs[2].ncyc = 0;
    vecs[2].w0_cyc = 0; vecs[2].w0_reg = 5; vecs[2].w0_data = 32'hAA;
    vecs[2].t0_reg = 0; vecs[2].t0_rf = 32'd1; vecs[2].t0_rom = 32'd2;
    vecs[2].e_err = 1; vecs[2].e_fv = 1'b1; vecs[2].e_freg = 0;
    vecs[2].e_fexp = 32'd2; vecs[2].e_fact = 32'd1;
    // Last register mismatch, writes on first and last RUN cycles.
    vecs[3].ncyc = 7;
    vecs[3].w0_cyc = 0; vecs[3].w0_reg = 2;  vecs[3].w0_data = 32'h55;
    vecs[3].w1_cyc = 6; vecs[3].w1_reg = 31; vecs[3].w1_data = 32'hDEAD;
    vecs[3].t0_reg = 31; vecs[3].t0_rf = 32'hA5A5; vecs[3].t0_rom = 32'h5A5A;
    vecs[3].t1_reg = 30; vecs[3].t1_rf = 32'd3;    vecs[3].t1_rom = 32'd3;
    vecs[3].e_err = 1; vecs[3].e_fv = 1'b1; vecs[3].e_freg = 31;
    vecs[3].e_fexp = 32'h5A5A; vecs[3].e_fact = 32'hA5A5;
    // 20 writes to r1, no pops: 16 kept, overflow set.
    vecs[4].ncyc = 20; vecs[4].burst = 1; vecs[4].b_reg = 1; vecs[4].e_ovf = 1'b1;
    // Fill, then push and pop together while full: no overflow.
    vecs[5].ncyc = 17; vecs[5].burst = 1; vecs[5].b_reg = 2; vecs[5].pop_cyc = 16;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    $display("reset: busy=%0b done=%0b err=%0d tv=%0b", busy, done, error_count, trace_valid);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_test_mode", test_mode, 0);
    chk("rst_error_count", error_count, 0);
    chk("rst_fail_valid", fail_valid, 0);
    chk("rst_trace_valid", trace_valid, 0);
    chk("rst_trace_overflow", trace_overflow, 0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset during SCAN with results and a trace entry pending.
    for (int i = 0; i < NUM_REGS; i++) begin
      rf[i] = 32'd0; rom[i] = 32'd0;
    end
    rf[2] = 32'd9;
    @(negedge clock);
    start = 1'b1; num_cycles = 16'd2;
    @(posedge clock);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clock);
      start = 1'b0; wb_en = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
      if (k == 0) begin
        wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'h77;
      end
    end
    $display("pre-reset: scan_addr=%0d err=%0d tv=%0b", scan_addr, error_count, trace_valid);
    chk("midscan_scan_addr", scan_addr, 10);
    chk("midscan_error_count", error_count, 1);
    chk("midscan_trace_valid", trace_valid, 1);
    reset = 1'b1;
    @(negedge clock);
    $display("post-reset: busy=%0b tm=%0b err=%0d fv=%0b tv=%0b",
             busy, test_mode, error_count, fail_valid, trace_valid);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_test_mode", test_mode, 0);
    chk("midreset_error_count", error_count, 0);
    chk("midreset_fail_valid", fail_valid, 0);
    chk("midreset_trace_valid", trace_valid, 0);
    reset = 1'b0;

    // A run from IDLE after the interrupted scan.
    run_vec(6, vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/harness_scan_checker.md
Name: harness_scan_checker

Overview:
- Synthesizable self-check harness that replaces the simulation-only register-compare loop and can also run on the FPGA.
- Observes processor writeback for a programmed number of cycles and logs each nonzero-register write into a trace FIFO.
- Then takes over regfile read port A, scans every register, compares it against an expected-value ROM, and reports the error count plus the first failure.

Parameters:
- DATA_W, 32, register/data width
- REG_ADDR_W, 5, register address width
- NUM_REGS, 32, registers scanned, addresses 0..NUM_REGS-1; must be <= 2^REG_ADDR_W
- CYCLE_W, 16, width of cycle counter and num_cycles
- TRACE_DEPTH, 16, trace FIFO entries; power of 2, >= 2

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begins a run from IDLE or DONE
- num_cycles  in  CYCLE_W  run length, sampled when start is accepted
- wb_en  in  1  processor ctrl_writeEnable
- wb_reg  in  REG_ADDR_W  processor ctrl_writeReg
- wb_data  in  DATA_W  processor data_writeReg
- test_mode  out  1  high: top level muxes scan_addr onto regfile readRegA
- scan_addr  out  REG_ADDR_W  register being scanned
- scan_data  in  DATA_W  regfile data_readRegA, combinational read
- exp_addr  out  REG_ADDR_W  expected-ROM address
- exp_data  in  DATA_W  expected-ROM output, 1-cycle registered latency
- busy  out  1  state is RUN or SCAN
- done  out  1  state is DONE
- pass  out  1  done and error_count==0
- error_count  out  REG_ADDR_W+1  number of mismatching registers
- fail_valid  out  1  at least one mismatch recorded
- fail_reg  out  REG_ADDR_W  first mismatching register
- fail_exp  out  DATA_W  expected value at first mismatch
- fail_act  out  DATA_W  actual value at first mismatch
- trace_rd  in  1  pop the trace FIFO
- trace_valid  out  1  FIFO not empty
- trace_cycle  out  CYCLE_W  cycle index of the head entry
- trace_reg  out  REG_ADDR_W  register of the head entry
- trace_data  out  DATA_W  data of the head entry
- trace_overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset:
  - Returns to IDLE from any state, including mid-RUN or mid-SCAN.
  - All outputs go to 0 and the FIFO is emptied.
  - Takes priority over start.
- States IDLE -> RUN -> SCAN -> DONE. start is ignored in RUN and SCAN.
- Start: accepted in IDLE or DONE. Clears error_count, fail_*, the FIFO and trace_overflow, and loads the cycle counter to 0.
- RUN:
  - Lasts exactly num_cycles clocks; counter runs 0..num_cycles-1.
  - num_cycles==0 goes straight to SCAN.
  - On each RUN edge with wb_en && wb_reg!=0, push {counter, wb_reg, wb_data}.
- SCAN:
  - test_mode=1; scan_addr=exp_addr=i, with i = 0..NUM_REGS-1, one per cycle.
  - Compare stage runs one cycle behind: registered scan_data(i) vs exp_data(i).
  - On mismatch, error_count+1; the first mismatch loads fail_* and sets fail_valid.
  - Last compare occurs NUM_REGS+1 cycles after SCAN entry, then state goes to DONE.
  - test_mode drops to 0 in the same cycle done rises.
- DONE: outputs hold until start or reset.
- Trace FIFO:
  - Push when full: entry is dropped and trace_overflow is set.
  - Push and pop in the same cycle when full: both are accepted.
  - Pop when empty: ignored.
  - Pops are allowed in every state; pushes occur only in RUN.
  - Head outputs are registered and valid when trace_valid=1.
- Width rules:
  - Cycle counter stops at num_cycles; it never wraps within a run.
  - error_count saturates only at NUM_REGS.

Decomposition:
- Shared package harness_pkg holds:
  - state enum {IDLE, RUN, SCAN, DONE};
  - trace entry struct {cycle, reg, data};
  - TRACE_W constant.
- One sub-module, harness_trace_fifo: parametrised width/depth, synchronous FIFO with full/empty and drop-on-full.

Test Plan:
- Run with num_cycles=5; writeback r3=7 at cycle 1 and r0=9 at cycle 2; ROM all zero except r3=7; regfile r3=7 -> FIFO holds exactly one entry {1,3,7}. done rises at cycle 5+NUM_REGS+1 after RUN entry; pass=1; error_count=0.
- Regfile r4=5 and r9=2 vs expected r4=6 and r9=2, plus r31=1 vs expected 0 -> error_count=2, fail_reg=4, fail_exp=6, fail_act=5, pass=0.
- 20 consecutive writes to r1 with TRACE_DEPTH=16 and no pops -> 16 entries with cycles 0..15, then trace_overflow=1. Pop all 16 -> trace_valid falls after the 16th pop.
- FIFO full, then a simultaneous push and pop -> count stays 16, trace_overflow stays 0, new tail entry present.
- num_cycles=0 -> SCAN starts the cycle after start, no FIFO pushes.
- reset asserted mid-SCAN at i=10 -> next cycle state is IDLE, test_mode=0, error_count=0, fail_valid=0, FIFO empty.
- start pulsed during RUN -> ignored.
- start in DONE -> fresh run with cleared results.
